// File: rtl/uart_cmd_pkg.sv
// Shared types and command constants for the Bluetooth command receiver.
package uart_cmd_pkg;

   typedef enum logic {IDLE, RECV} rx_state_t;
   typedef enum logic [1:0] {OFF, PWR1, PWR2} auth_state_t;

   localparam logic [7:0] CMD_GO   = 8'h47;
   localparam logic [7:0] CMD_STOP = 8'h53;
   localparam int         BAUD_W   = 13;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, rx_rdy handshake and framing error.
module uart_rx_core
   import uart_cmd_pkg::*;
#(
   parameter int BAUD_DIV = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       frame_err
);

   localparam logic [BAUD_W-1:0] FULL = BAUD_W'(BAUD_DIV);
   localparam logic [BAUD_W-1:0] HALF = BAUD_W'(BAUD_DIV / 2);

   rx_state_t         state, state_nxt;
   logic              rx_s1, rx_s2, rx_prev;
   logic [1:0]        fill;
   logic [BAUD_W-1:0] baud_cnt;
   logic [3:0]        bit_cnt;
   logic [9:0]        shift, shift_nxt;
   logic              start_edge, sample, done;

   assign shift_nxt = {rx_s2, shift[9:1]};

   always_comb begin
      state_nxt  = state;
      start_edge = 1'b0;
      sample     = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (rx_prev && !rx_s2) begin
               start_edge = 1'b1;
               state_nxt  = RECV;
            end
         end
         RECV: begin
            if (baud_cnt == BAUD_W'(1)) begin
               sample = 1'b1;
               if (bit_cnt == 4'd9) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // rx_prev only holds 1 once a genuine high has passed the synchronizer, so a line
   // that is already low when reset releases cannot fake a start edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
         fill      <= 2'b00;
         rx_prev   <= 1'b0;
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         rx_data   <= 8'h00;
         rx_rdy    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_s1     <= rx;
         rx_s2     <= rx_s1;
         fill      <= {fill[0], 1'b1};
         rx_prev   <= fill[1] & rx_s2;
         state     <= state_nxt;
         frame_err <= 1'b0;
         if (start_edge) begin
            baud_cnt <= HALF;
            bit_cnt  <= 4'd0;
         end else if (sample) begin
            baud_cnt <= FULL;
            bit_cnt  <= bit_cnt + 4'd1;
            shift    <= shift_nxt;
         end else if (state == RECV) begin
            baud_cnt <= baud_cnt - BAUD_W'(1);
         end
         if (done && shift_nxt[9]) begin
            rx_data <= shift_nxt[8:1];
            rx_rdy  <= 1'b1;
         end else if (clr_rdy || start_edge) begin
            rx_rdy <= 1'b0;
         end
         if (done && !shift_nxt[9]) begin
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_cmd_auth.sv
// Command endpoint: receives UART bytes and turns GO/STOP commands into pwr_up,
// deferring power-down until the rider has stepped off.
module uart_cmd_auth
   import uart_cmd_pkg::*;
#(
   parameter int         BAUD_DIV = 5208,
   parameter logic [7:0] GO_CMD   = CMD_GO,
   parameter logic [7:0] STOP_CMD = CMD_STOP
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       rider_off,
   output logic       pwr_up,
   output logic [7:0] rx_data,
   output logic       rx_rdy,
   output logic       frame_err
);

   auth_state_t state, state_nxt;
   logic        clr_rdy;

   uart_rx_core #(
      .BAUD_DIV (BAUD_DIV)
   ) u_rx (
      .clk       (clk),
      .rst       (rst),
      .rx        (RX),
      .clr_rdy   (clr_rdy),
      .rx_data   (rx_data),
      .rx_rdy    (rx_rdy),
      .frame_err (frame_err)
   );

   // Every byte is consumed exactly once, whether or not it changes state.
   assign clr_rdy = rx_rdy;
   assign pwr_up  = (state != OFF);

   always_comb begin
      state_nxt = state;
      case (state)
         OFF: begin
            if (rx_rdy && rx_data == GO_CMD) state_nxt = PWR1;
         end
         PWR1: begin
            if (rx_rdy && rx_data == STOP_CMD) state_nxt = rider_off ? OFF : PWR2;
         end
         PWR2: begin
            if (rider_off)                        state_nxt = OFF;
            else if (rx_rdy && rx_data == GO_CMD) state_nxt = PWR1;
         end
         default: state_nxt = OFF;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= OFF;
      else     state <= state_nxt;
   end

endmodule

// File: tb/tb_uart_cmd_auth.sv
// Directed bench for uart_cmd_auth at a short baud divisor to keep frames brief.
module tb_uart_cmd_auth;

   localparam int B   = 16;
   localparam int LAT = 3 + B / 2 + 9 * B;

   logic       clk = 1'b0;
   logic       rst, RX, rider_off;
   logic       pwr_up, rx_rdy, frame_err;
   logic [7:0] rx_data;

   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         rdy_count = 0, rdy_long = 0, ferr_count = 0;
   int         rdy_cycle = 0, fall_cycle = 0;
   logic [7:0] rdy_data = 8'h00;
   logic       pwr_at_rdy = 1'b0, pwr_after = 1'b0, rdy_prev = 1'b0;

   uart_cmd_auth #(.BAUD_DIV(B)) dut (
      .clk       (clk),
      .rst       (rst),
      .RX        (RX),
      .rider_off (rider_off),
      .pwr_up    (pwr_up),
      .rx_data   (rx_data),
      .rx_rdy    (rx_rdy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   // Record rx_rdy / frame_err activity and the pwr_up value just after each rx_rdy.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rdy_prev) pwr_after = pwr_up;
      if (rdy_prev && rx_rdy) rdy_long = rdy_long + 1;
      if (rx_rdy) begin
         rdy_count  = rdy_count + 1;
         rdy_data   = rx_data;
         rdy_cycle  = cyc;
         pwr_at_rdy = pwr_up;
      end
      if (frame_err) ferr_count = ferr_count + 1;
      rdy_prev = rx_rdy;
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic clear_counts();
      rdy_count  = 0;
      rdy_long   = 0;
      ferr_count = 0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      RX = 1'b0;
      fall_cycle = cyc;
      step(B);
      for (int i = 0; i < 8; i++) begin
         RX = d[i];
         step(B);
      end
      RX = stop;
      step(B);
      RX = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      RX = 1'b1;
      rider_off = 1'b0;
      step(3);
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL reset_pwr_up: got %0b want 0", pwr_up); end
      checks++; if (rx_rdy !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_rdy: got %0b want 0", rx_rdy); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err: got %0b want 0", frame_err); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data: got %0h want 00", rx_data); end
      rst = 1'b0;
      clear_counts();
      step(20);
      checks++; if (rdy_count != 0) begin failures++; $display("[TB] FAIL idle_no_rdy: got %0d want 0", rdy_count); end
   endtask

   task automatic test_power_up();
      int lat;
      clear_counts();
      send_frame(8'h47, 1'b1);
      step(4);
      lat = rdy_cycle - fall_cycle;
      checks++; if (rdy_count != 1) begin failures++; $display("[TB] FAIL pu_rdy_count: got %0d want 1", rdy_count); end
      checks++; if (rdy_long != 0) begin failures++; $display("[TB] FAIL pu_rdy_width: got %0d extra cycles want 0", rdy_long); end
      checks++; if (rdy_data !== 8'h47) begin failures++; $display("[TB] FAIL pu_rdy_data: got %0h want 47", rdy_data); end
      checks++; if (lat < LAT - 1 || lat > LAT + 1) begin failures++; $display("[TB] FAIL pu_latency: got %0d want %0d", lat, LAT); end
      checks++; if (pwr_at_rdy !== 1'b0) begin failures++; $display("[TB] FAIL pu_pwr_during_rdy: got %0b want 0", pwr_at_rdy); end
      checks++; if (pwr_after !== 1'b1) begin failures++; $display("[TB] FAIL pu_pwr_after_rdy: got %0b want 1", pwr_after); end
      checks++; if (rx_data !== 8'h47) begin failures++; $display("[TB] FAIL pu_rx_data_held: got %0h want 47", rx_data); end
   endtask

   task automatic test_deferred_stop();
      rider_off = 1'b0;
      clear_counts();
      send_frame(8'h53, 1'b1);
      step(4);
      checks++; if (rdy_count != 1) begin failures++; $display("[TB] FAIL ds_rdy_count: got %0d want 1", rdy_count); end
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL ds_pwr2_hold: got %0b want 1", pwr_up); end
      rider_off = 1'b1;
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL ds_pwr_before_edge: got %0b want 1", pwr_up); end
      step(1);
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL ds_rider_off_drop: got %0b want 0", pwr_up); end
      rider_off = 1'b0;
      send_frame(8'h47, 1'b1);
      step(2);
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL ds_repower: got %0b want 1", pwr_up); end
      rider_off = 1'b1;
      send_frame(8'h53, 1'b1);
      step(2);
      checks++; if (pwr_at_rdy !== 1'b1) begin failures++; $display("[TB] FAIL ds_stop_pwr_at_rdy: got %0b want 1", pwr_at_rdy); end
      checks++; if (pwr_after !== 1'b0) begin failures++; $display("[TB] FAIL ds_stop_immediate: got %0b want 0", pwr_after); end
      rider_off = 1'b0;
   endtask

   task automatic test_ignored();
      clear_counts();
      send_frame(8'h41, 1'b1);
      step(2);
      checks++; if (rdy_count != 1) begin failures++; $display("[TB] FAIL ig_off_rdy_count: got %0d want 1", rdy_count); end
      checks++; if (rdy_data !== 8'h41) begin failures++; $display("[TB] FAIL ig_off_data: got %0h want 41", rdy_data); end
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL ig_off_pwr: got %0b want 0", pwr_up); end
      send_frame(8'h47, 1'b1);
      step(2);
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL ig_go_pwr: got %0b want 1", pwr_up); end
      clear_counts();
      send_frame(8'h47, 1'b1);
      step(2);
      checks++; if (rdy_count != 1) begin failures++; $display("[TB] FAIL ig_pwr1_rdy_count: got %0d want 1", rdy_count); end
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL ig_pwr1_pwr: got %0b want 1", pwr_up); end
      rider_off = 1'b1;
      send_frame(8'h53, 1'b1);
      step(2);
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL ig_stop_off: got %0b want 0", pwr_up); end
      rider_off = 1'b0;
   endtask

   task automatic test_rider_priority();
      send_frame(8'h47, 1'b1);
      send_frame(8'h53, 1'b1);
      step(4);
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL rp_in_pwr2: got %0b want 1", pwr_up); end
      fork
         send_frame(8'h47, 1'b1);
         begin
            int n;
            n = 0;
            while (rx_rdy !== 1'b1 && n < 400) begin
               step(1);
               n++;
            end
            checks++;
            if (rx_rdy === 1'b1) rider_off = 1'b1;
            else begin failures++; $display("[TB] FAIL rp_wait_rdy: got timeout want rx_rdy"); end
         end
      join
      step(1);
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL rp_rider_wins: got %0b want 0", pwr_up); end
      rider_off = 1'b0;
   endtask

   task automatic test_frame_err();
      clear_counts();
      send_frame(8'h47, 1'b0);
      step(B);
      checks++; if (ferr_count != 1) begin failures++; $display("[TB] FAIL fe_pulse_count: got %0d want 1", ferr_count); end
      checks++; if (rdy_count != 0) begin failures++; $display("[TB] FAIL fe_no_rdy: got %0d want 0", rdy_count); end
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL fe_pwr: got %0b want 0", pwr_up); end
      checks++; if (rx_data !== 8'h47) begin failures++; $display("[TB] FAIL fe_data_held: got %0h want 47", rx_data); end
      send_frame(8'h47, 1'b1);
      step(2);
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL fe_recover_pwr: got %0b want 1", pwr_up); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      d = 8'h47;
      clear_counts();
      RX = 1'b0;
      step(B);
      for (int i = 0; i < 5; i++) begin
         RX = d[i];
         step(B);
      end
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(3 * B);
      checks++; if (rdy_count != 0) begin failures++; $display("[TB] FAIL rm_no_rdy: got %0d want 0", rdy_count); end
      checks++; if (ferr_count != 0) begin failures++; $display("[TB] FAIL rm_no_ferr: got %0d want 0", ferr_count); end
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL rm_pwr: got %0b want 0", pwr_up); end
      RX = 1'b1;
      step(B);
      rider_off = 1'b1;
      send_frame(8'h47, 1'b1);
      checks++; if (pwr_up !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_go: got %0b want 1", pwr_up); end
      send_frame(8'h53, 1'b1);
      step(2);
      checks++; if (rdy_count != 2) begin failures++; $display("[TB] FAIL b2b_rdy_count: got %0d want 2", rdy_count); end
      checks++; if (rx_data !== 8'h53) begin failures++; $display("[TB] FAIL b2b_last_data: got %0h want 53", rx_data); end
      checks++; if (pwr_up !== 1'b0) begin failures++; $display("[TB] FAIL b2b_final_pwr: got %0b want 0", pwr_up); end
      rider_off = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_deferred_stop();
      test_ignored();
      test_rider_priority();
      test_frame_err();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_cmd_auth.md
# uart_cmd_auth

Receive-side endpoint of the Bluetooth command link. It deserializes 8N1 UART frames on `RX` and decodes the start byte `G` (0x47) and stop byte `S` (0x53) into the `pwr_up` enable that gates the balance controller. A stop request defers power-down until the rider has stepped off. It sits inside `Segway` directly behind the `RX` pin, replacing the bare receiver plus glue logic.

## Interface
- `BAUD_DIV`, default 5208: clocks per bit (50 MHz, 9600 baud); legal range 16..8191.
- `GO_CMD`, default 8'h47: byte that powers up.
- `STOP_CMD`, default 8'h53: byte that requests power-down.
- `clk` input, 1 bit: single system clock; everything is on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `RX` input, 1 bit: asynchronous serial line; idles high.
- `rider_off` input, 1 bit: synchronous, from the load-cell logic; 1 means no rider is present.
- `pwr_up` output, 1 bit: enables the balance controller and steering.
- `rx_data` output, 8 bits: last byte received, held until the next byte completes.
- `rx_rdy` output, 1 bit: a valid byte is in `rx_data` and has not yet been consumed by the auth FSM.
- `frame_err` output, 1 bit: one-cycle pulse when the stop bit sampled low.

## Operation
- **Synchronizer:** `RX` passes through two flops, both reset to 1. All receive logic uses the synchronized value.
- **Receiver states:**
  - IDLE: a 1→0 transition on the synchronized `RX` moves to RECV. The baud counter loads `BAUD_DIV/2` and the bit counter loads 0.
  - RECV: when the baud counter expires, sample the line into a 10-bit shift register (LSB first), reload the counter with `BAUD_DIV`, and increment the bit counter.
  - After the 10th sample, return to IDLE and latch `rx_data` from the data bits.
  - Stop bit = 1: set `rx_rdy`.
  - Stop bit = 0: pulse `frame_err`; `rx_data` and `rx_rdy` stay unchanged.
- **Start bit:** not re-validated. A glitch is consumed as a frame and normally ends in `frame_err`.
- **Clearing `rx_rdy`:** cleared by the internal `clr_rdy` or by detection of a new start edge, whichever comes first.
- **Auth FSM:** Moore. `pwr_up` = 1 in PWR1 and PWR2. Each `rx_rdy` is consumed exactly once: `clr_rdy` is asserted in any cycle where `rx_rdy` = 1.
  - OFF: `rx_rdy` with `GO_CMD` → PWR1. Any other byte is consumed and ignored.
  - PWR1: `rx_rdy` with `STOP_CMD` → OFF if `rider_off` = 1, otherwise → PWR2. Any other byte (including `GO_CMD`) is ignored.
  - PWR2: `rider_off` = 1 → OFF, regardless of `rx_rdy`. Otherwise, `rx_rdy` with `GO_CMD` → PWR1.
- **Simultaneous events:** in PWR2, `rider_off` wins over a `GO_CMD` arriving in the same cycle.

## Timing
- **Reset values:** `pwr_up` = 0, `rx_rdy` = 0, `frame_err` = 0, `rx_data` = 8'h00, both FSMs idle/OFF, synchronizer = 1.
- **Frame to `rx_rdy`:** `rx_rdy` rises 2 (synchronizer) + 1 (edge detect) + `BAUD_DIV/2` + 9×`BAUD_DIV` cycles after the `RX` falling edge, ±1 cycle.
- **`rx_rdy` to `pwr_up`:** `pwr_up` changes on the edge after the `rx_rdy` cycle. `rx_rdy` drops on that same edge, so `rx_rdy` is high for exactly 1 cycle.
- **`rider_off` in PWR2:** `pwr_up` falls 1 cycle after `rider_off` is seen high.
- **Back-to-back frames:** a start bit immediately after a stop bit is accepted, since IDLE is re-entered at the stop-bit midpoint.
- **Reset mid-frame:** the partial byte is discarded and no `rx_rdy` is produced. After release, a line already low waits for a high-to-low edge before receiving.

## Structure
- **Package `uart_cmd_pkg`:** `rx_state_t` {IDLE, RECV}, `auth_state_t` {OFF, PWR1, PWR2}, and the constants `CMD_GO` = 8'h47 and `CMD_STOP` = 8'h53.
- **Sub-module `uart_rx_core`:** synchronizer, baud and bit counters, shift register, `rx_rdy`/`clr_rdy` handshake, `frame_err`. The auth FSM lives in the top level.

## Test plan
- **Reset:** assert `rst` with `RX` = 1 → all outputs at reset values. Hold 20 cycles idle → no `rx_rdy`.
- **Power-up:** send 0x47 → `rx_data` = 0x47, a single 1-cycle `rx_rdy`, and `pwr_up` = 1 one cycle later, about 49 480 cycles after the start edge.
- **Deferred power-down:** with `pwr_up` = 1 and `rider_off` = 0, send 0x53 → `pwr_up` stays 1 (PWR2). Raise `rider_off` → `pwr_up` = 0 next cycle. Repeat with `rider_off` = 1 held during 0x53 → `pwr_up` = 0 one cycle after `rx_rdy`.
- **Ignored bytes:** send 0x41 in OFF and 0x47 in PWR1 → `rx_rdy` pulses and `pwr_up` is unchanged.
- **Framing error:** send 0x47 with the stop bit driven low → `frame_err` pulses once, `rx_rdy` stays 0, `pwr_up` stays 0. A subsequent good 0x47 still powers up.
- **Reset mid-frame:** pulse `rst` after bit 4 of 0x47 → no `rx_rdy` and `pwr_up` = 0. A back-to-back 0x47, 0x53 pair with `rider_off` = 1 → both bytes received, ending with `pwr_up` = 0.
